// File: rtl/sram_1p_req_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the 1-port SRAM
// request controller and its response FIFO.
package sram_ctrl_pkg;

    localparam int LANE_W = 9;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } state_e;

    // Bits needed to hold the values 0..n (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sram_1p_req_ctrl_if.sv
// Request/response channel between an initiator and the SRAM request controller.
interface sram_1p_req_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 144
);
    import sram_ctrl_pkg::*;

    localparam int LANES = DW / LANE_W;

    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_WR;
    logic [AW-1:0]    REQ_ADDR;
    logic [DW-1:0]    REQ_WDATA;
    logic [LANES-1:0] REQ_BE;
    logic             RSP_VALID;
    logic             RSP_READY;
    logic [DW-1:0]    RSP_DATA;

    modport master (
        output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, REQ_BE, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_DATA
    );

    modport slave (
        input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, REQ_BE, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_DATA
    );

endinterface

// File: rtl/sram_1p_req_ctrl_rsp_fifo.sv
// Flop-based response FIFO; the head entry is presented combinationally
// whenever the count is non-zero.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int  DW    = 144,
    parameter int  DEPTH = 3,
    localparam int CW    = cnt_width(DEPTH),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic [DW-1:0] o_head
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // The controller's credit check must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(i_push && !w_pop && (r_count == CW'(DEPTH))));
    end

endmodule

// File: rtl/sram_1p_req_ctrl.sv
// Initiator-side controller for a 1-port 144b x 32 SRAM macro: request to
// strobe conversion, credit-protected read response FIFO and idle sleep.
//
//   state  | meaning
//   ACTIVE | accepting requests while response credits remain; counts idle cycles
//   SLEEP  | SRAM_SLP high, no requests accepted; any REQ_VALID starts a wake
//   WAKE   | SRAM_SLP low, waiting WAKE_CYC cycles before the next access
module sram_1p_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int  AW        = 5,
    parameter int  DW        = 144,
    parameter int  RSP_DEPTH = 3,
    parameter int  IDLE_CYC  = 16,
    parameter int  WAKE_CYC  = 2,
    localparam int LANES     = DW / LANE_W
) (
    input  logic              CLK,
    input  logic              RSTN,
    sram_1p_req_ctrl_if.slave bus,
    output logic              SRAM_CEN,
    output logic              SRAM_GWEN,
    output logic [LANES-1:0]  SRAM_WEN,
    output logic [AW-1:0]     SRAM_A,
    output logic [DW-1:0]     SRAM_D,
    output logic              SRAM_SLP,
    input  logic [DW-1:0]     SRAM_Q
);

    localparam int CW = cnt_width(RSP_DEPTH);
    localparam int IW = cnt_width(IDLE_CYC);
    localparam int WW = cnt_width(WAKE_CYC);

    localparam logic [1:0] S_ACTIVE = ACTIVE;
    localparam logic [1:0] S_SLEEP  = SLEEP;
    localparam logic [1:0] S_WAKE   = WAKE;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idle_cnt;
    logic [WW-1:0] r_wake_cnt;
    logic          r_rd_pend;
    logic          r_slp;
    logic [CW-1:0] w_fifo_cnt;
    logic          w_ready;
    logic          w_accept;
    logic          w_idle;

    // A read in flight to the SRAM already owns a FIFO slot; pops give no same-cycle credit.
    assign w_ready  = RSTN && (r_state == S_ACTIVE) &&
                      (({1'b0, w_fifo_cnt} + (CW+1)'(r_rd_pend)) < (CW+1)'(RSP_DEPTH));
    assign w_accept = bus.REQ_VALID && w_ready;
    assign w_idle   = !w_accept && !r_rd_pend;

    assign bus.REQ_READY = w_ready;
    assign bus.RSP_VALID = (w_fifo_cnt != '0);

    assign SRAM_CEN  = !w_accept;
    assign SRAM_GWEN = !(w_accept && bus.REQ_WR);
    assign SRAM_WEN  = ~({LANES{w_accept && bus.REQ_WR}} & bus.REQ_BE);
    assign SRAM_A    = bus.REQ_ADDR;
    assign SRAM_D    = bus.REQ_WDATA;
    assign SRAM_SLP  = r_slp;

    sram_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (CLK),
        .rst_n   (RSTN),
        .i_push  (r_rd_pend),
        .i_data  (SRAM_Q),
        .i_pop   (bus.RSP_VALID && bus.RSP_READY),
        .o_count (w_fifo_cnt),
        .o_head  (bus.RSP_DATA)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_ACTIVE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_slp      <= 1'b0;
        end else begin
            r_rd_pend <= w_accept && !bus.REQ_WR;
            case (r_state)
                S_ACTIVE: begin
                    if (w_accept) begin
                        r_idle_cnt <= '0;
                    end else if (w_idle) begin
                        if ((IDLE_CYC != 0) && (r_idle_cnt == IW'(IDLE_CYC - 1))) begin
                            r_state    <= S_SLEEP;
                            r_slp      <= 1'b1;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end
                S_SLEEP: begin
                    if (bus.REQ_VALID) begin
                        r_state    <= S_WAKE;
                        r_slp      <= 1'b0;
                        r_wake_cnt <= '0;
                    end
                end
                S_WAKE: begin
                    if (r_wake_cnt == WW'(WAKE_CYC - 1)) r_state <= S_ACTIVE;
                    else                                 r_wake_cnt <= r_wake_cnt + 1'b1;
                end
                default: r_state <= S_ACTIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_1p_req_ctrl.sv
// Self-checking bench for sram_1p_req_ctrl: SRAM macro model, directed
// scenarios and randomized traffic against a queue-based reference model.
module tb_sram_1p_req_ctrl;
    import sram_ctrl_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 144;
    localparam int LANES = DW / LANE_W;
    localparam int DEPTH = 3;
    localparam int IDLE  = 16;
    localparam int WAKEC = 2;
    localparam int M_ACTIVE = 0;
    localparam int M_SLEEP  = 1;
    localparam int M_WAKE   = 2;

    logic             CLK;
    logic             RSTN;
    logic             SRAM_CEN;
    logic             SRAM_GWEN;
    logic [LANES-1:0] SRAM_WEN;
    logic [AW-1:0]    SRAM_A;
    logic [DW-1:0]    SRAM_D;
    logic             SRAM_SLP;
    logic [DW-1:0]    SRAM_Q;

    sram_1p_req_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sram_1p_req_ctrl #(
        .AW(AW), .DW(DW), .RSP_DEPTH(DEPTH), .IDLE_CYC(IDLE), .WAKE_CYC(WAKEC)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .bus       (bus),
        .SRAM_CEN  (SRAM_CEN),
        .SRAM_GWEN (SRAM_GWEN),
        .SRAM_WEN  (SRAM_WEN),
        .SRAM_A    (SRAM_A),
        .SRAM_D    (SRAM_D),
        .SRAM_SLP  (SRAM_SLP),
        .SRAM_Q    (SRAM_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM macro: active-low strobes, 9-bit lane writes, 1-cycle read latency.
    logic [DW-1:0] sram_mem [1<<AW];
    always @(posedge CLK) begin
        if (!SRAM_CEN) begin
            if (!SRAM_GWEN) begin
                for (int i = 0; i < LANES; i++)
                    if (!SRAM_WEN[i]) sram_mem[SRAM_A][i*LANE_W +: LANE_W] <= SRAM_D[i*LANE_W +: LANE_W];
            end else begin
                SRAM_Q <= sram_mem[SRAM_A];
            end
        end
    end

    // Reference model: expected memory contents and in-order response queue.
    typedef struct {
        int            avail;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] shadow [1<<AW];
    int            m_mode, m_idle, m_wake, cyc;
    bit            m_prev_rd;
    int            checks, errors;
    bit            rnd_done;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        bit               exp_ready, exp_valid, acc, idle;
        logic [LANES-1:0] exp_wen;
        cyc++;
        if (!RSTN) begin
            exp_q.delete();
            m_mode = M_ACTIVE; m_idle = 0; m_wake = 0; m_prev_rd = 0;
            check_val("ready_in_rst", DW'(bus.REQ_READY), DW'(1'b0));
            check_val("cen_in_rst", DW'(SRAM_CEN), DW'(1'b1));
            check_val("rsp_valid_in_rst", DW'(bus.RSP_VALID), DW'(1'b0));
            check_val("slp_in_rst", DW'(SRAM_SLP), DW'(1'b0));
        end else begin
            exp_ready = (m_mode == M_ACTIVE) && (exp_q.size() < DEPTH);
            exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            acc       = exp_ready && bus.REQ_VALID;
            for (int i = 0; i < LANES; i++) exp_wen[i] = !(acc && bus.REQ_WR && bus.REQ_BE[i]);
            check_val("req_ready", DW'(bus.REQ_READY), DW'(exp_ready));
            check_val("rsp_valid", DW'(bus.RSP_VALID), DW'(exp_valid));
            if (exp_valid) check_val("rsp_data", bus.RSP_DATA, exp_q[0].data);
            check_val("sram_slp", DW'(SRAM_SLP), DW'(m_mode == M_SLEEP));
            check_val("sram_cen", DW'(SRAM_CEN), DW'(!acc));
            check_val("sram_gwen", DW'(SRAM_GWEN), DW'(!(acc && bus.REQ_WR)));
            check_val("sram_wen", DW'(SRAM_WEN), DW'(exp_wen));
            check_val("sram_a", DW'(SRAM_A), DW'(bus.REQ_ADDR));
            check_val("sram_d", SRAM_D, bus.REQ_WDATA);
            if (!SRAM_CEN) check_val("access_while_slp", DW'(SRAM_SLP), DW'(1'b0));

            if (exp_valid && bus.RSP_READY) void'(exp_q.pop_front());
            if (acc && bus.REQ_WR) begin
                for (int i = 0; i < LANES; i++)
                    if (bus.REQ_BE[i]) shadow[bus.REQ_ADDR][i*LANE_W +: LANE_W] = bus.REQ_WDATA[i*LANE_W +: LANE_W];
            end else if (acc) begin
                exp_q.push_back('{avail: cyc + 2, data: shadow[bus.REQ_ADDR]});
            end

            idle = !acc && !m_prev_rd;
            case (m_mode)
                M_ACTIVE: begin
                    if (acc) m_idle = 0;
                    else if (idle) begin
                        m_idle++;
                        if (IDLE != 0 && m_idle == IDLE) begin
                            m_mode = M_SLEEP;
                            m_idle = 0;
                        end
                    end
                end
                M_SLEEP: if (bus.REQ_VALID) begin m_mode = M_WAKE; m_wake = 0; end
                default: begin
                    m_wake++;
                    if (m_wake == WAKEC) m_mode = M_ACTIVE;
                end
            endcase
            m_prev_rd = acc && !bus.REQ_WR;
        end
    end

    function automatic logic [DW-1:0] rand_word();
        return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Hold a request until it is accepted; called and returns at posedge+1.
    task automatic send(input bit wr, input int addr, input logic [DW-1:0] d, input logic [LANES-1:0] be);
        bit got;
        int budget;
        got = 0;
        budget = 100;
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = wr;
        bus.REQ_ADDR  = AW'(addr);
        bus.REQ_WDATA = d;
        bus.REQ_BE    = be;
        while (!got && budget > 0) begin
            @(negedge CLK); #1;
            got = bus.REQ_READY;
            @(posedge CLK); #1;
            budget--;
        end
        if (!got) check_val("send_timeout", DW'(got), DW'(1'b1));
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 60;
        bus.RSP_READY = 1'b1;
        while (budget > 0 && (bus.RSP_VALID || exp_q.size() > 0)) begin
            idle_cycles(1);
            budget--;
        end
        if (budget == 0) check_val("drain_timeout", DW'(bus.RSP_VALID), DW'(1'b0));
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; rnd_done = 0;
        m_mode = M_ACTIVE; m_idle = 0; m_wake = 0; m_prev_rd = 0;
        RSTN = 1'b0;
        SRAM_Q = '0;
        bus.REQ_VALID = 1'b0; bus.REQ_WR = 1'b0; bus.REQ_ADDR = '0;
        bus.REQ_WDATA = '0; bus.REQ_BE = '0; bus.RSP_READY = 1'b0;
        for (int i = 0; i < (1<<AW); i++) begin
            sram_mem[i] = '0;
            shadow[i]   = '0;
        end
        idle_cycles(3);
        RSTN = 1'b1;

        // Full-width write then read back at addr 3.
        bus.RSP_READY = 1'b1;
        send(1'b1, 3, {12{12'h5A5}}, '1);
        send(1'b0, 3, '0, '0);
        idle_cycles(4);

        // Single-lane write of zeros over all-ones, plus a zero-enable write.
        send(1'b1, 7, '1, '1);
        send(1'b1, 7, '0, LANES'(1));
        send(1'b1, 7, '0, '0);
        send(1'b0, 7, '0, '0);
        idle_cycles(4);

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 10; i++) send(1'b0, i, '0, '0);
        idle_cycles(5);

        // Same reads with the response channel stalled, then released.
        bus.RSP_READY = 1'b0;
        fork
            for (int i = 0; i < 10; i++) send(1'b0, i, '0, '0);
            begin idle_cycles(12); bus.RSP_READY = 1'b1; end
        join
        wait_drain();

        // Idle into sleep, then wake with a read.
        idle_cycles(20);
        send(1'b0, 3, '0, '0);
        idle_cycles(4);

        // Reset with one read in flight and two responses queued.
        bus.RSP_READY = 1'b0;
        send(1'b0, 1, '0, '0);
        send(1'b0, 2, '0, '0);
        send(1'b0, 3, '0, '0);
        RSTN = 1'b0;
        idle_cycles(2);
        RSTN = 1'b1;
        @(negedge CLK); #1;
        check_val("post_rst_rsp_valid", DW'(bus.RSP_VALID), DW'(1'b0));
        check_val("post_rst_slp", DW'(SRAM_SLP), DW'(1'b0));
        check_val("post_rst_ready", DW'(bus.REQ_READY), DW'(1'b1));
        @(posedge CLK); #1;
        bus.RSP_READY = 1'b1;
        idle_cycles(6);

        // Randomized traffic with random back-pressure and occasional long gaps.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    int               r;
                    logic [LANES-1:0] be;
                    r = $urandom_range(0, 9);
                    if (r == 0)     idle_cycles($urandom_range(14, 22));
                    else if (r < 4) idle_cycles($urandom_range(1, 3));
                    case ($urandom_range(0, 7))
                        0:       be = '0;
                        1:       be = '1;
                        default: be = LANES'({$urandom, $urandom});
                    endcase
                    send(1'($urandom_range(0, 1)), $urandom_range(0, (1<<AW) - 1), rand_word(), be);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK); #1;
                    bus.RSP_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        wait_drain();
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
